// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate data cache between a load/store unit and memory.
// Supports hit reporting, per-line dirty bits, read-/write-through and whole-cache flush.
module dm_cache #(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int NUM_LINES      = 4
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         w_en,
  input  logic                         r_en,
  input  logic                         write_through,
  input  logic                         read_through,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [31:0]                  data_store,
  output logic [31:0]                  data_load,
  output logic                         done,
  output logic                         cache_hit,
  output logic                         flush_done,
  input  logic [WORDS_PER_LINE*32-1:0] line_read,
  output logic [WORDS_PER_LINE*32-1:0] line_store,
  input  logic                         mem_done,
  output logic                         mem_w_line,
  output logic                         mem_r_line,
  output logic                         mem_w_one,
  output logic                         mem_r_one,
  output logic [ADDR_W-1:0]            mem_addr
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [3:0] {
    IDLE, ACCESS, EVICT, FILL, THRU, RESP, FL_SCAN, FL_WB, FL_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_d [NUM_LINES];
  logic                 op_wr_q, op_wr_d;
  logic                 op_thru_q, op_thru_d;
  logic [IDX_W-1:0]     fl_idx_q, fl_idx_d;
  logic [31:0]          data_load_q, data_load_d;
  logic                 cache_hit_q, cache_hit_d;

  logic [31:0]          ram_q [NUM_LINES][WORDS_PER_LINE];
  logic                 ram_we_word, ram_we_line;

  logic [OFF_W-1:0]     off;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit;
  logic [IDX_W-1:0]     sel_idx;
  logic [WORDS_PER_LINE*32-1:0] sel_line;

  assign off = addr[OFF_W-1:0];
  assign idx = addr[OFF_W +: IDX_W];
  assign tag = addr[ADDR_W-1 -: TAG_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  // Victim line for write-back: the flush walker's line during a flush, else the addressed line
  assign sel_idx = (state_q == FL_WB) ? fl_idx_q : idx;

  always_comb begin
    sel_line = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      sel_line[w*32 +: 32] = ram_q[sel_idx][w];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
      op_wr_q     <= 1'b0;
      op_thru_q   <= 1'b0;
      fl_idx_q    <= '0;
      data_load_q <= '0;
      cache_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      op_wr_q     <= op_wr_d;
      op_thru_q   <= op_thru_d;
      fl_idx_q    <= fl_idx_d;
      data_load_q <= data_load_d;
      cache_hit_q <= cache_hit_d;
    end
  end

  // Data RAM carries no reset; valid bits gate its use
  always_ff @(posedge clk) begin
    if (ram_we_line) begin
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        ram_q[idx][w] <= line_read[w*32 +: 32];
      end
    end else if (ram_we_word) begin
      ram_q[idx][off] <= data_store;
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    op_wr_d     = op_wr_q;
    op_thru_d   = op_thru_q;
    fl_idx_d    = fl_idx_q;
    data_load_d = data_load_q;
    cache_hit_d = cache_hit_q;
    ram_we_word = 1'b0;
    ram_we_line = 1'b0;
    mem_w_line  = 1'b0;
    mem_r_line  = 1'b0;
    mem_w_one   = 1'b0;
    mem_r_one   = 1'b0;
    mem_addr    = '0;
    line_store  = '0;

    case (state_q)
      IDLE: begin
        if (w_en) begin
          op_wr_d     = 1'b1;
          op_thru_d   = write_through;
          cache_hit_d = hit;
          if (hit)                state_d = ACCESS;
          else if (write_through) state_d = THRU;
          else if (dirty_q[idx])  state_d = EVICT;
          else                    state_d = FILL;
        end else if (r_en) begin
          op_wr_d     = 1'b0;
          op_thru_d   = read_through;
          cache_hit_d = hit;
          if (read_through)       state_d = (hit && dirty_q[idx]) ? EVICT : THRU;
          else if (hit)           state_d = ACCESS;
          else if (dirty_q[idx])  state_d = EVICT;
          else                    state_d = FILL;
        end else if (flush) begin
          fl_idx_d = '0;
          state_d  = FL_SCAN;
        end
      end
      ACCESS: begin
        if (op_wr_q) begin
          ram_we_word = 1'b1;
          if (!op_thru_q) dirty_d[idx] = 1'b1;
          state_d = op_thru_q ? THRU : RESP;
        end else begin
          data_load_d = ram_q[idx][off];
          state_d     = RESP;
        end
      end
      EVICT: begin
        mem_w_line = 1'b1;
        mem_addr   = {tag_q[idx], idx, {OFF_W{1'b0}}};
        line_store = sel_line;
        if (mem_done) begin
          dirty_d[idx] = 1'b0;
          // Only a read-through load reaches EVICT with the through flag set
          state_d = op_thru_q ? THRU : FILL;
        end
      end
      FILL: begin
        mem_r_line = 1'b1;
        mem_addr   = {tag, idx, {OFF_W{1'b0}}};
        if (mem_done) begin
          ram_we_line  = 1'b1;
          valid_d[idx] = 1'b1;
          tag_d[idx]   = tag;
          state_d      = ACCESS;
        end
      end
      THRU: begin
        mem_addr = addr;
        if (op_wr_q) begin
          mem_w_one        = 1'b1;
          line_store[31:0] = data_store;
        end else begin
          mem_r_one = 1'b1;
        end
        if (mem_done) begin
          if (!op_wr_q) data_load_d = line_read[31:0];
          state_d = RESP;
        end
      end
      RESP: begin
        if (!w_en && !r_en) state_d = IDLE;
      end
      FL_SCAN: begin
        if (valid_q[fl_idx_q] && dirty_q[fl_idx_q]) state_d = FL_WB;
        else if (fl_idx_q == IDX_W'(NUM_LINES-1))   state_d = FL_DONE;
        else                                        fl_idx_d = fl_idx_q + IDX_W'(1);
      end
      FL_WB: begin
        mem_w_line = 1'b1;
        mem_addr   = {tag_q[fl_idx_q], fl_idx_q, {OFF_W{1'b0}}};
        line_store = sel_line;
        if (mem_done) begin
          dirty_d[fl_idx_q] = 1'b0;
          if (fl_idx_q == IDX_W'(NUM_LINES-1)) begin
            state_d = FL_DONE;
          end else begin
            fl_idx_d = fl_idx_q + IDX_W'(1);
            state_d  = FL_SCAN;
          end
        end
      end
      FL_DONE: begin
        if (!flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done       = (state_q == RESP);
  assign flush_done = (state_q == FL_DONE);
  assign data_load  = data_load_q;
  assign cache_hit  = cache_hit_q;

endmodule

// File: tb/tb_dm_cache.sv
// Bench for dm_cache: vector table plus scoreboard queues for responses and memory ops,
// with a behavioural memory responder and hand-written flush/reset sequences.
module tb_dm_cache;

  localparam int ADDR_W = 32;
  localparam int WPL    = 8;
  localparam int NL     = 4;

  localparam int K_WL = 1;
  localparam int K_RL = 2;
  localparam int K_WO = 3;
  localparam int K_RO = 4;

  logic              clk = 1'b0;
  logic              rst_l = 1'b1;
  logic              w_en = 1'b0, r_en = 1'b0;
  logic              write_through = 1'b0, read_through = 1'b0, flush = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       data_store = '0;
  logic [31:0]       data_load;
  logic              done, cache_hit, flush_done;
  logic [WPL*32-1:0] line_read = '0;
  logic [WPL*32-1:0] line_store;
  logic              mem_done = 1'b0;
  logic              mem_w_line, mem_r_line, mem_w_one, mem_r_one;
  logic [ADDR_W-1:0] mem_addr;

  dm_cache #(.ADDR_W(ADDR_W), .WORDS_PER_LINE(WPL), .NUM_LINES(NL)) dut (
    .clk(clk), .rst_l(rst_l), .w_en(w_en), .r_en(r_en),
    .write_through(write_through), .read_through(read_through), .flush(flush),
    .addr(addr), .data_store(data_store), .data_load(data_load), .done(done),
    .cache_hit(cache_hit), .flush_done(flush_done), .line_read(line_read),
    .line_store(line_store), .mem_done(mem_done), .mem_w_line(mem_w_line),
    .mem_r_line(mem_r_line), .mem_w_one(mem_w_one), .mem_r_one(mem_r_one),
    .mem_addr(mem_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we, re, wt, rt;
    logic [31:0] ad, dt;
    bit          hit, chk_load;
    logic [31:0] load;
    int          lat;
    int          k1; logic [31:0] a1; int w1; logic [31:0] v1;
    int          k2; logic [31:0] a2; int w2; logic [31:0] v2;
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    int          widx;
    logic [31:0] wval;
  } memop_t;

  typedef struct {
    bit          hit, chk_load;
    logic [31:0] load;
    int          lat;
  } rsp_t;

  memop_t      exp_mq[$];
  rsp_t        exp_rq[$];
  vec_t        tv[$];
  logic [31:0] mem_m [logic [31:0]];
  int          n_chk = 0, n_pass = 0, n_memops = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic logic [31:0] rd(logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic vec_t mk(bit we, bit re, bit wt, bit rt, logic [31:0] ad, logic [31:0] dt,
                              bit hit, bit cl, logic [31:0] ld, int lat,
                              int k1, logic [31:0] a1, int w1, logic [31:0] v1,
                              int k2, logic [31:0] a2, int w2, logic [31:0] v2);
    vec_t v;
    v.we = we; v.re = re; v.wt = wt; v.rt = rt; v.ad = ad; v.dt = dt;
    v.hit = hit; v.chk_load = cl; v.load = ld; v.lat = lat;
    v.k1 = k1; v.a1 = a1; v.w1 = w1; v.v1 = v1;
    v.k2 = k2; v.a2 = a2; v.w2 = w2; v.v2 = v2;
    return v;
  endfunction

  function automatic memop_t mo(int k, logic [31:0] a, int w, logic [31:0] v);
    memop_t m;
    m.kind = k; m.addr = a; m.widx = w; m.wval = v;
    return m;
  endfunction

  // Behavioural memory: checks each strobe against the expected-op queue, then answers
  initial begin
    int          kind;
    logic [31:0] a;
    memop_t      e;
    forever begin
      @(negedge clk);
      if (rst_l && (mem_w_line || mem_r_line || mem_w_one || mem_r_one)) begin
        kind = mem_w_line ? K_WL : mem_r_line ? K_RL : mem_w_one ? K_WO : K_RO;
        a = mem_addr;
        n_memops++;
        chk("one_strobe", $countones({mem_w_line, mem_r_line, mem_w_one, mem_r_one}), 1);
        if (exp_mq.size() == 0) begin
          chk("unexpected_memop_kind", kind, 0);
        end else begin
          e = exp_mq.pop_front();
          chk("memop_kind", kind, e.kind);
          chk("memop_addr", a, e.addr);
          if (e.widx >= 0) chk("memop_word", line_store[e.widx*32 +: 32], e.wval);
        end
        case (kind)
          K_WL: for (int i = 0; i < WPL; i++) mem_m[a + 32'(i)] = line_store[i*32 +: 32];
          K_RL: for (int i = 0; i < WPL; i++) line_read[i*32 +: 32] = rd(a + 32'(i));
          K_WO: mem_m[a] = line_store[31:0];
          default: begin line_read = '0; line_read[31:0] = rd(a); end
        endcase
        repeat (2) @(negedge clk);
        if (rst_l && (mem_w_line || mem_r_line || mem_w_one || mem_r_one)) begin
          chk("memop_addr_stable", mem_addr, a);
          mem_done = 1'b1;
          @(negedge clk);
          mem_done = 1'b0;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int id);
    rsp_t r;
    int   edges;
    if (v.k1 != 0) exp_mq.push_back(mo(v.k1, v.a1, v.w1, v.v1));
    if (v.k2 != 0) exp_mq.push_back(mo(v.k2, v.a2, v.w2, v.v2));
    r.hit = v.hit; r.chk_load = v.chk_load; r.load = v.load; r.lat = v.lat;
    exp_rq.push_back(r);
    @(negedge clk);
    w_en = v.we; r_en = v.re; write_through = v.wt; read_through = v.rt;
    addr = v.ad; data_store = v.dt;
    edges = 0;
    do begin @(posedge clk); #1; edges++; end while (!done && edges < 200);
    chk($sformatf("v%0d_done", id), done, 1);
    r = exp_rq.pop_front();
    chk($sformatf("v%0d_cache_hit", id), cache_hit, r.hit);
    if (r.chk_load) chk($sformatf("v%0d_data_load", id), data_load, r.load);
    if (r.lat != 0) chk($sformatf("v%0d_latency", id), edges, r.lat);
    @(negedge clk);
    w_en = 0; r_en = 0; write_through = 0; read_through = 0;
    edges = 0;
    while (done && edges < 20) begin @(posedge clk); #1; edges++; end
    chk($sformatf("v%0d_done_drop", id), done, 0);
    chk($sformatf("v%0d_memq_drained", id), exp_mq.size(), 0);
    exp_mq.delete();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_strobes"}, {mem_w_line, mem_r_line, mem_w_one, mem_r_one}, 0);
    chk({nm, "_done"}, {flush_done, done}, 0);
    chk({nm, "_cache_hit"}, cache_hit, 0);
    chk({nm, "_data_load"}, data_load, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_line_store"}, {31'b0, |line_store}, 0);
  endtask

  task automatic run_flush(input string nm);
    int edges;
    @(negedge clk);
    flush = 1;
    edges = 0;
    do begin @(posedge clk); #1; edges++; end while (!flush_done && edges < 300);
    chk({nm, "_flush_done"}, flush_done, 1);
    @(negedge clk);
    flush = 0;
    edges = 0;
    while (flush_done && edges < 20) begin @(posedge clk); #1; edges++; end
    chk({nm, "_flush_done_drop"}, flush_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ops0;
    int edges;
    //       we re wt rt addr      data           hit ld load           lat  op1                              op2
    tv.push_back(mk(0,1,0,0, 32'h40,  0,            0,1, 32'hC0DE0040, 0, K_RL,32'h40,-1,0, 0,0,-1,0));
    tv.push_back(mk(0,1,0,0, 32'h40,  0,            1,1, 32'hC0DE0040, 2, 0,0,-1,0, 0,0,-1,0));
    tv.push_back(mk(1,0,0,0, 32'h41,  32'hDEADBEEF, 1,0, 0,            2, 0,0,-1,0, 0,0,-1,0));
    tv.push_back(mk(0,1,0,0, 32'h60,  0,            0,1, 32'hC0DE0060, 0, K_WL,32'h40,1,32'hDEADBEEF, K_RL,32'h60,-1,0));
    tv.push_back(mk(0,1,0,0, 32'h41,  0,            0,1, 32'hDEADBEEF, 0, K_RL,32'h40,-1,0, 0,0,-1,0));
    tv.push_back(mk(1,0,1,0, 32'h41,  32'h12345678, 1,0, 0,            0, K_WO,32'h41,0,32'h12345678, 0,0,-1,0));
    tv.push_back(mk(0,1,0,0, 32'h41,  0,            1,1, 32'h12345678, 2, 0,0,-1,0, 0,0,-1,0));
    tv.push_back(mk(0,1,0,1, 32'h41,  0,            1,1, 32'h12345678, 0, K_RO,32'h41,-1,0, 0,0,-1,0));
    tv.push_back(mk(1,0,0,0, 32'h42,  32'hAAAA0002, 1,0, 0,            2, 0,0,-1,0, 0,0,-1,0));
    tv.push_back(mk(1,0,0,0, 32'h50,  32'hBBBB0050, 0,0, 0,            0, K_RL,32'h50,-1,0, 0,0,-1,0));
    // after the flush
    tv.push_back(mk(1,0,0,0, 32'h43,  32'hCCCC0043, 1,0, 0,            2, 0,0,-1,0, 0,0,-1,0));
    tv.push_back(mk(0,1,0,1, 32'h42,  0,            1,1, 32'hAAAA0002, 0, K_WL,32'h40,3,32'hCCCC0043, K_RO,32'h42,-1,0));
    tv.push_back(mk(1,0,1,0, 32'h100, 32'h00000077, 0,0, 0,            0, K_WO,32'h100,0,32'h77, 0,0,-1,0));
    tv.push_back(mk(0,1,0,0, 32'h100, 0,            0,1, 32'h00000077, 0, K_RL,32'h100,-1,0, 0,0,-1,0));
    tv.push_back(mk(1,1,0,0, 32'h101, 32'h00000055, 1,0, 0,            2, 0,0,-1,0, 0,0,-1,0));
    tv.push_back(mk(0,1,0,0, 32'h101, 0,            1,1, 32'h00000055, 2, 0,0,-1,0, 0,0,-1,0));
    tv.push_back(mk(0,1,0,0, 32'h50,  0,            1,1, 32'hBBBB0050, 2, 0,0,-1,0, 0,0,-1,0));
    // after the mid-FILL reset
    tv.push_back(mk(0,1,0,0, 32'h48,  0,            0,1, 32'hC0DE0048, 0, K_RL,32'h48,-1,0, 0,0,-1,0));
    tv.push_back(mk(0,1,0,0, 32'h40,  0,            0,1, 32'hC0DE0040, 0, K_RL,32'h40,-1,0, 0,0,-1,0));

    #2 rst_l = 0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_l = 1;

    for (int i = 0; i < 10; i++) run_vec(tv[i], i);

    exp_mq.push_back(mo(K_WL, 32'h40, 2, 32'hAAAA0002));
    exp_mq.push_back(mo(K_WL, 32'h50, 0, 32'hBBBB0050));
    run_flush("flush1");
    chk("flush1_memq_drained", exp_mq.size(), 0);
    exp_mq.delete();
    ops0 = n_memops;
    run_flush("flush2");
    chk("flush2_memops", n_memops - ops0, 0);

    for (int i = 10; i < 17; i++) run_vec(tv[i], i);

    @(negedge clk);
    r_en = 1; addr = 32'h48;
    edges = 0;
    do begin @(posedge clk); #1; edges++; end while (!mem_r_line && edges < 20);
    chk("midfill_strobe_seen", mem_r_line, 1);
    #1 rst_l = 0;
    r_en = 0;
    #1 chk_reset_outputs("midfill_reset");
    repeat (2) @(negedge clk);
    rst_l = 1;

    for (int i = 17; i < 19; i++) run_vec(tv[i], i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
